seg7_time_decoder: RTL and testbench
====================================

// Module: seg7_time_decoder
// PURPOSE
//  Receive-side counterpart of the alarm clock's display encoder. Samples the six active-low
//  7-segment digit buses (HH:MM:SS) and filters out transient patterns. Decodes stable patterns
//  back to binary hr/min/sec and range-checks them. Offers each new value on a valid/ready port
//  to downstream time-sync and self-check logic, and flags whether it is exactly +1 s from the
//  previous value.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical input cycles required before a value is accepted (>=1)
//  CNT_W          8  width of the stability counter; must hold STABLE_CYCLES
// PORTS
//  clk          in   1  system clock
//  RST          in   1  reset, asynchronous, active-high
//  ss7_lsd      in   7  seconds units pattern, active-low {g,f,e,d,c,b,a}
//  ss7_msd      in   7  seconds tens pattern
//  mm7_lsd      in   7  minutes units pattern
//  mm7_msd      in   7  minutes tens pattern
//  hh7_lsd      in   7  hours units pattern
//  hh7_msd      in   7  hours tens pattern
//  out_ready    in   1  downstream accepts the offered value
//  clr_err      in   1  synchronous clear of the sticky flags
//  out_valid    out  1  hr/min/sec/seq_ok hold a new, unconsumed value
//  hr           out  6  decoded hours 0..23
//  min          out  6  decoded minutes 0..59
//  sec          out  6  decoded seconds 0..59
//  seq_ok       out  1  offered value == previous published value + 1 s
//  err_pattern  out  1  sticky: a stable digit pattern was not one of 0..9
//  err_range    out  1  sticky: a stable value was out of range
//  overrun      out  1  sticky: an offered value was overwritten before being consumed
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; stability count 0.
//   - Snapshot = six copies of 7'b1000000 ("0").
//   - "previous published" marked invalid.
//  Stability filter:
//   - snap <= 42-bit input every cycle.
//   - If input != snap, count <= 0; otherwise count increments, saturating at STABLE_CYCLES.
//   - Accept strobe: count reaches STABLE_CYCLES this cycle AND (snap != last published
//     pattern OR previous is invalid).
//   - Each stable value is accepted once only.
//  Decode stage (1 registered cycle after accept):
//   - Per digit, 0..9 map to 1000000,1111001,0100100,0110000,0011001,0010010,0000010,
//     1111000,0000000,0010000.
//   - Any other pattern, including blank 1111111, is invalid.
//   - value = msd*10 + lsd, 6-bit result.
//   - Tens limits: sec/min msd <= 5, hr msd <= 2, and hr <= 23.
//   - Any invalid digit: err_pattern <= 1, no publish, previous unchanged.
//   - Any range violation: err_range <= 1, no publish, previous unchanged.
//  Output FSM, states EMPTY and PEND:
//   - Publish in EMPTY: load hr/min/sec/seq_ok, out_valid <= 1, go to PEND.
//   - Publish in PEND: overwrite data, overrun <= 1, stay in PEND.
//   - PEND && out_ready with no publish: out_valid <= 0 next cycle, go to EMPTY.
//   - PEND && out_ready with a same-cycle publish: new data loaded, out_valid stays 1,
//     overrun is NOT set.
//  Latency: input held constant from cycle 0 (differing from snap) -> out_valid high at
//   cycle STABLE_CYCLES+2.
//  seq_ok: computed against the previous published time plus 1 s.
//   - sec 59 -> 0 carries into min; min 59 -> 0 carries into hr; 23:59:59 -> 00:00:00.
//   - seq_ok = 0 when previous is invalid (first value after reset).
//  Sticky flags: cleared by clr_err. A set event in the same cycle wins over clr_err.
//  Reset mid-operation: pending value discarded, out_valid drops immediately (async),
//   filter restarts.
// STRUCTURE
//  - seg7_pkg: segment pattern constants for 0..9 and blank, FSM state enum, MAX_HR=23,
//    MAX_MS=59.
//  - Sub-module seg7_digit_dec: 7-bit pattern in -> 4-bit digit + valid out, purely
//    combinational.
//  - Instantiated 6 times; filter, decode register, FSM and seq logic stay in the top.
// TESTING
//  T1 reset, inputs held at "00:00:00" -> out_valid at cycle STABLE_CYCLES+2;
//     hr=min=sec=0, seq_ok=0.
//  T2 12:34:56 stable, out_ready=1 -> hr=12 min=34 sec=56, out_valid 1 cycle;
//     then 12:34:57 -> seq_ok=1.
//  T3 23:59:59 then 00:00:00 -> seq_ok=1; 10:00:00 then 10:00:02 -> seq_ok=0.
//  T4 ss7_lsd glitched for STABLE_CYCLES-1 cycles then restored -> no new out_valid,
//     no flags.
//  T5 mm7_msd=1111111 -> err_pattern=1, no valid; hours "25" (0100100,0010010) -> err_range=1;
//     clr_err -> both 0.
//  T6 out_ready=0, publish 01:00:00 then 01:00:01 -> overrun=1, sec=1;
//     out_ready=1 -> out_valid 0 next cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment time decoder: active-low digit patterns,
// time limits and the output FSM state type.
package seg7_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns as produced by the display encoder
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [5:0] MAX_HR = 6'd23;
  localparam logic [5:0] MAX_MS = 6'd59;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_PEND  = 1'b1
  } out_state_e;

  function automatic logic [6:0] bcd_join(input logic [3:0] msd, input logic [3:0] lsd);
    return ({3'd0, msd} * 7'd10) + {3'd0, lsd};
  endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Maps one active-low 7-segment pattern back to its decimal digit; anything
// that is not an exact 0..9 pattern (blank included) is flagged invalid.
module seg7_digit_dec
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       valid
);

  // Exact-match lookup against the encoder table
  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: valid = 1'b0;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_time_decoder.sv
// Receive-side HH:MM:SS decoder: filters the six digit buses for stability,
// decodes and range-checks them, and offers each new time on a valid/ready port.
module seg7_time_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic [6:0] ss7_lsd,
  input  logic [6:0] ss7_msd,
  input  logic [6:0] mm7_lsd,
  input  logic [6:0] mm7_msd,
  input  logic [6:0] hh7_lsd,
  input  logic [6:0] hh7_msd,
  input  logic       out_ready,
  input  logic       clr_err,
  output logic       out_valid,
  output logic [5:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       seq_ok,
  output logic       err_pattern,
  output logic       err_range,
  output logic       overrun
);

  localparam logic [41:0]      SNAP_RST = {6{SEG_0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [41:0]      raw_s;
  logic [41:0]      snap_r;
  logic [CNT_W-1:0] cnt_r;
  logic             same_s;
  logic             accept_s;

  logic [3:0]       dig_s [6];
  logic [5:0]       dv_s;
  logic [6:0]       hr_v_s, min_v_s, sec_v_s;
  logic             pat_ok_s, rng_ok_s;

  logic             stg_go_r, stg_pat_ok_r, stg_rng_ok_r;
  logic [5:0]       stg_hr_r, stg_min_r, stg_sec_r;
  logic [41:0]      stg_pat_r;

  out_state_e       state_r;
  logic             prev_valid_r;
  logic [5:0]       prev_hr_r, prev_min_r, prev_sec_r;
  logic [41:0]      pub_pat_r;
  logic [5:0]       nxt_hr_s, nxt_min_s, nxt_sec_s;
  logic             seq_hit_s, publish_s;
  logic             pat_err_set_s, rng_err_set_s, ovr_set_s;

  assign raw_s  = {hh7_msd, hh7_lsd, mm7_msd, mm7_lsd, ss7_msd, ss7_lsd};
  assign same_s = (raw_s == snap_r);
  // Fires only on the cycle the count first reaches the threshold, so a held value is taken once
  assign accept_s = same_s && (cnt_r == CNT_LAST) && (!prev_valid_r || (snap_r != pub_pat_r));

  // Stability filter: snapshot plus saturating run-length counter
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      snap_r <= SNAP_RST;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      snap_r <= raw_s;
      if (!same_s) cnt_r <= {CNT_W{1'b0}};
      else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < 6; i++) begin : g_dig
    seg7_digit_dec u_dec (
      .pattern (snap_r[7*i +: 7]),
      .digit   (dig_s[i]),
      .valid   (dv_s[i])
    );
  end

  assign sec_v_s  = bcd_join(dig_s[1], dig_s[0]);
  assign min_v_s  = bcd_join(dig_s[3], dig_s[2]);
  assign hr_v_s   = bcd_join(dig_s[5], dig_s[4]);
  assign pat_ok_s = &dv_s;
  assign rng_ok_s = (dig_s[1] <= 4'd5) && (dig_s[3] <= 4'd5) && (dig_s[5] <= 4'd2) &&
                    (hr_v_s <= {1'b0, MAX_HR}) && (min_v_s <= {1'b0, MAX_MS}) &&
                    (sec_v_s <= {1'b0, MAX_MS});

  // Decode stage: capture the checked value one cycle after acceptance
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stg_go_r     <= 1'b0;
      stg_pat_ok_r <= 1'b0;
      stg_rng_ok_r <= 1'b0;
      stg_hr_r     <= 6'd0;
      stg_min_r    <= 6'd0;
      stg_sec_r    <= 6'd0;
      stg_pat_r    <= SNAP_RST;
    end else begin
      stg_go_r <= accept_s;
      if (accept_s) begin
        stg_pat_ok_r <= pat_ok_s;
        stg_rng_ok_r <= rng_ok_s;
        stg_hr_r     <= hr_v_s[5:0];
        stg_min_r    <= min_v_s[5:0];
        stg_sec_r    <= sec_v_s[5:0];
        stg_pat_r    <= snap_r;
      end
    end
  end

  // Previous published time advanced by one second, with day wrap
  always_comb begin
    nxt_hr_s  = prev_hr_r;
    nxt_min_s = prev_min_r;
    nxt_sec_s = prev_sec_r + 6'd1;
    if (prev_sec_r == MAX_MS) begin
      nxt_sec_s = 6'd0;
      if (prev_min_r == MAX_MS) begin
        nxt_min_s = 6'd0;
        if (prev_hr_r == MAX_HR) nxt_hr_s = 6'd0;
        else nxt_hr_s = prev_hr_r + 6'd1;
      end else begin
        nxt_min_s = prev_min_r + 6'd1;
      end
    end else begin
      nxt_sec_s = prev_sec_r + 6'd1;
    end
  end

  assign seq_hit_s     = prev_valid_r && (stg_hr_r == nxt_hr_s) &&
                         (stg_min_r == nxt_min_s) && (stg_sec_r == nxt_sec_s);
  assign publish_s     = stg_go_r && stg_pat_ok_r && stg_rng_ok_r;
  assign pat_err_set_s = stg_go_r && !stg_pat_ok_r;
  assign rng_err_set_s = stg_go_r && stg_pat_ok_r && !stg_rng_ok_r;
  assign ovr_set_s     = (state_r == ST_PEND) && publish_s && !out_ready;

  // Output FSM with registered offer, history of the last published time and overrun flag
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_r      <= ST_EMPTY;
      out_valid    <= 1'b0;
      hr           <= 6'd0;
      min          <= 6'd0;
      sec          <= 6'd0;
      seq_ok       <= 1'b0;
      overrun      <= 1'b0;
      prev_valid_r <= 1'b0;
      prev_hr_r    <= 6'd0;
      prev_min_r   <= 6'd0;
      prev_sec_r   <= 6'd0;
      pub_pat_r    <= SNAP_RST;
    end else begin
      if (publish_s) begin
        hr           <= stg_hr_r;
        min          <= stg_min_r;
        sec          <= stg_sec_r;
        seq_ok       <= seq_hit_s;
        prev_valid_r <= 1'b1;
        prev_hr_r    <= stg_hr_r;
        prev_min_r   <= stg_min_r;
        prev_sec_r   <= stg_sec_r;
        pub_pat_r    <= stg_pat_r;
      end
      case (state_r)
        ST_EMPTY: begin
          if (publish_s) begin
            out_valid <= 1'b1;
            state_r   <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (!publish_s && out_ready) begin
            out_valid <= 1'b0;
            state_r   <= ST_EMPTY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= ST_EMPTY;
        end
      endcase
      overrun <= ovr_set_s | (overrun & ~clr_err);
    end
  end

  // Sticky decode error flags; a new error outranks a same-cycle clear
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      err_pattern <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      err_pattern <= pat_err_set_s | (err_pattern & ~clr_err);
      err_range   <= rng_err_set_s | (err_range & ~clr_err);
    end
  end

endmodule

// File: tb/tb_seg7_time_decoder.sv
// Self-checking bench for seg7_time_decoder: vector table through a handshake
// scoreboard plus directed glitch, error, overrun and reset sequences.
module tb_seg7_time_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       RST;
  logic [6:0] ss7_lsd, ss7_msd, mm7_lsd, mm7_msd, hh7_lsd, hh7_msd;
  logic       out_ready, clr_err;
  logic       out_valid, seq_ok, err_pattern, err_range, overrun;
  logic [5:0] hr, min, sec;

  seg7_time_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk(clk), .RST(RST),
    .ss7_lsd(ss7_lsd), .ss7_msd(ss7_msd), .mm7_lsd(mm7_lsd),
    .mm7_msd(mm7_msd), .hh7_lsd(hh7_lsd), .hh7_msd(hh7_msd),
    .out_ready(out_ready), .clr_err(clr_err),
    .out_valid(out_valid), .hr(hr), .min(min), .sec(sec), .seq_ok(seq_ok),
    .err_pattern(err_pattern), .err_range(err_range), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int h; int m; int s; int eh; int em; int es; int eseq; } vec_t;
  typedef struct { logic [5:0] h; logic [5:0] m; logic [5:0] s; logic sq; } exp_t;

  logic [6:0] seg_lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  exp_t sbq[$];
  vec_t tbl[8];
  int   checks = 0;
  int   failures = 0;
  int   seen;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int h, input int m, input int s, input int sq);
    exp_t e;
    e.h = 6'(h); e.m = 6'(m); e.s = 6'(s); e.sq = 1'(sq);
    sbq.push_back(e);
  endtask

  // Scoreboard side: compare every accepted handshake against the oldest expectation
  task automatic sb_sample();
    exp_t e;
    if (!RST && out_valid && out_ready) begin
      chk("sb_expected_present", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_hr", hr, e.h);
        chk("sb_min", min, e.m);
        chk("sb_sec", sec, e.s);
        chk("sb_seq_ok", seq_ok, e.sq);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic steps_count_valid(input int n, output int rises);
    rises = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (out_valid) rises++;
    end
  endtask

  task automatic drive(input int h, input int m, input int s);
    hh7_msd = seg_lut[h / 10]; hh7_lsd = seg_lut[h % 10];
    mm7_msd = seg_lut[m / 10]; mm7_lsd = seg_lut[m % 10];
    ss7_msd = seg_lut[s / 10]; ss7_lsd = seg_lut[s % 10];
  endtask

  initial begin
    tbl[0] = '{12, 34, 56, 12, 34, 56, 0};
    tbl[1] = '{12, 34, 57, 12, 34, 57, 1};
    tbl[2] = '{23, 59, 59, 23, 59, 59, 0};
    tbl[3] = '{ 0,  0,  0,  0,  0,  0, 1};
    tbl[4] = '{10,  0,  0, 10,  0,  0, 0};
    tbl[5] = '{10,  0,  2, 10,  0,  2, 0};
    tbl[6] = '{ 9, 59, 59,  9, 59, 59, 0};
    tbl[7] = '{10,  0,  0, 10,  0,  0, 1};

    // T1: reset state, then 00:00:00 held from reset
    RST = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
    drive(0, 0, 0);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_hr", hr, 0);
    chk("rst_min", min, 0);
    chk("rst_sec", sec, 0);
    chk("rst_seq_ok", seq_ok, 0);
    chk("rst_flags", {err_pattern, err_range, overrun}, 0);
    @(posedge clk); #1;
    RST = 1'b0;
    for (int k = 0; k < S + 2; k++) step();
    chk("t1_valid", out_valid, 1);
    chk("t1_time", {hr, min, sec}, 0);
    chk("t1_seq_ok", seq_ok, 0);
    push_exp(0, 0, 0, 0);
    out_ready = 1'b1;
    step();
    chk("t1_valid_drop", out_valid, 0);

    // T2/T3: table of times through the scoreboard, with exact latency
    foreach (tbl[i]) begin
      drive(tbl[i].h, tbl[i].m, tbl[i].s);
      push_exp(tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].eseq);
      for (int k = 0; k < S + 1; k++) step();
      chk("vec_early_valid", out_valid, 0);
      step();
      chk("vec_latency_valid", out_valid, 1);
      step();
      chk("vec_valid_one_cycle", out_valid, 0);
      step();
    end
    chk("vec_no_flags", {err_pattern, err_range, overrun}, 0);

    // T4: short glitch on seconds units, then restored
    ss7_lsd = seg_lut[5];
    steps_count_valid(S - 1, seen);
    chk("t4_glitch_valid", seen, 0);
    ss7_lsd = seg_lut[0];
    steps_count_valid(2 * S + 2, seen);
    chk("t4_restore_valid", seen, 0);
    chk("t4_no_flags", {err_pattern, err_range, overrun}, 0);

    // T5: blank digit with a clear landing on the set edge, then hours "25"
    mm7_msd = 7'b1111111;
    steps_count_valid(S + 1, seen);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t5_pattern_set_beats_clr", err_pattern, 1);
    chk("t5_pattern_no_range", err_range, 0);
    drive(25, 0, 0);
    steps_count_valid(S + 3, seen);
    chk("t5_no_valid", seen, 0);
    chk("t5_range_set", err_range, 1);
    chk("t5_pattern_held", err_pattern, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t5_clr", {err_pattern, err_range}, 0);

    // T6: overwrite before consumption
    out_ready = 1'b0;
    drive(1, 0, 0);
    for (int k = 0; k < S + 3; k++) step();
    chk("t6_first_valid", out_valid, 1);
    chk("t6_first_no_overrun", overrun, 0);
    drive(1, 0, 1);
    for (int k = 0; k < S + 3; k++) step();
    chk("t6_overrun", overrun, 1);
    chk("t6_sec", sec, 1);
    chk("t6_seq_ok", seq_ok, 1);
    push_exp(1, 0, 1, 1);
    out_ready = 1'b1;
    step();
    chk("t6_valid_drop", out_valid, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t6_overrun_clr", overrun, 0);

    // Consume and publish in the same cycle: no overrun
    out_ready = 1'b0;
    drive(1, 0, 2);
    for (int k = 0; k < S + 3; k++) step();
    chk("same_cyc_pending", out_valid, 1);
    drive(1, 0, 3);
    for (int k = 0; k < S + 1; k++) step();
    push_exp(1, 0, 2, 1);
    push_exp(1, 0, 3, 1);
    out_ready = 1'b1;
    step();
    chk("same_cyc_valid_held", out_valid, 1);
    chk("same_cyc_sec", sec, 3);
    chk("same_cyc_no_overrun", overrun, 0);
    step();
    chk("same_cyc_drop", out_valid, 0);

    // Asynchronous reset with a value pending, then restart
    out_ready = 1'b0;
    drive(2, 0, 0);
    for (int k = 0; k < S + 3; k++) step();
    chk("mid_rst_pending", out_valid, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_valid_async", out_valid, 0);
    chk("mid_rst_hr", hr, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_exp(2, 0, 0, 0);
    RST = 1'b0;
    for (int k = 0; k < S + 1; k++) step();
    chk("mid_rst_early_valid", out_valid, 0);
    step();
    chk("mid_rst_latency_valid", out_valid, 1);
    step();
    chk("mid_rst_drop", out_valid, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
